// File: rtl/encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_if
//  Description : Character-in / symbol-out bundle for the 8b/10b encoder.
//                The master side presents bytes; the slave side returns
//                10-bit symbols, the error flag and the running disparity.
//  Revision    : 1.0  initial release
// ============================================================================
interface encoder_if;
    logic [7:0] TxParallel_8;
    logic       TxDataK;
    logic       TxValid;
    logic [9:0] TxParallel_10;
    logic       TxValid_10;
    logic       code_error;
    logic       RunDisp;

    modport master (
        output TxParallel_8, TxDataK, TxValid,
        input  TxParallel_10, TxValid_10, code_error, RunDisp
    );

    modport slave (
        input  TxParallel_8, TxDataK, TxValid,
        output TxParallel_10, TxValid_10, code_error, RunDisp
    );
endinterface
`default_nettype wire

// File: rtl/encoder.sv
`default_nettype none
// ============================================================================
//  Module      : encoder
//  Description : IEEE 802.3 clause 36 8b/10b encoder. One character per
//                clock, one cycle latency, registered outputs. Unsupported
//                K characters are sent as the matching D character and
//                flagged on code_error.
//  Revision    : 1.0  initial release
// ============================================================================
module encoder (
    input  wire logic BitCLK_10,
    input  wire logic Reset,
    encoder_if.slave  bus
);
    localparam logic [5:0] c_K28_6B = 6'b001111;   // K28 6b code, RD- column
    localparam logic [3:0] c_A7_4B  = 4'b0111;     // alternate y=7 code, RD- column

    // Data 5b/6b table, RD- column, written abcdei (a is the MSB here).
    function automatic logic [5:0] data6Neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // Data 3b/4b table (primary codes), RD- column, written fghj.
    function automatic logic [3:0] data4Neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;  3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // K28 3b/4b table, RD- column; every RD+ entry is the complement.
    function automatic logic [3:0] k4Neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;  3'd1: c = 4'b0110;
            3'd2: c = 4'b1010;  3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;  3'd5: c = 4'b0101;
            3'd6: c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    // Running disparity after a 6b sub-block.
    function automatic logic rdAfter6(input logic rd, input logic [5:0] s);
        logic r;
        if ($countones(s) > 3)      r = 1'b1;
        else if ($countones(s) < 3) r = 1'b0;
        else if (s == 6'b000111)    r = 1'b1;
        else if (s == 6'b111000)    r = 1'b0;
        else                        r = rd;
        return r;
    endfunction

    // Running disparity after a 4b sub-block.
    function automatic logic rdAfter4(input logic rd, input logic [3:0] s);
        logic r;
        if ($countones(s) > 2)      r = 1'b1;
        else if ($countones(s) < 2) r = 1'b0;
        else if (s == 4'b0011)      r = 1'b1;
        else if (s == 4'b1100)      r = 1'b0;
        else                        r = rd;
        return r;
    endfunction

    // abcdeifghj (a first) to the output layout with a at bit 0.
    function automatic logic [9:0] toWire(input logic [9:0] s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[9 - i];
        return r;
    endfunction

    logic [9:0] r_sym;
    logic       r_valid;
    logic       r_err;
    logic       r_rd;

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_isK28;
    logic       w_isKx7;
    logic       w_kErr;
    logic [5:0] w_6neg;
    logic       w_6comp;
    logic [5:0] w_6;
    logic       w_rdMid;
    logic       w_useA7;
    logic [3:0] w_4neg;
    logic       w_4comp;
    logic [3:0] w_4;
    logic       w_rdEnd;

    assign w_x     = bus.TxParallel_8[4:0];
    assign w_y     = bus.TxParallel_8[7:5];
    assign w_isK28 = bus.TxDataK && (w_x == 5'd28);
    assign w_isKx7 = bus.TxDataK && (w_y == 3'd7) &&
                     (w_x inside {5'd23, 5'd27, 5'd29, 5'd30});
    assign w_kErr  = bus.TxDataK && !w_isK28 && !w_isKx7;

    // 6b sub-block: unbalanced codes and D.7 flip polarity at RD+.
    assign w_6neg  = w_isK28 ? c_K28_6B : data6Neg(w_x);
    assign w_6comp = ($countones(w_6neg) != 3) || (w_x == 5'd7);
    assign w_6     = (r_rd && w_6comp) ? ~w_6neg : w_6neg;
    assign w_rdMid = rdAfter6(r_rd, w_6);

    // A7 avoids a run of five across the 6b/4b boundary; K23/27/29/30.7 always use it.
    assign w_useA7 = !w_isK28 && (w_y == 3'd7) &&
                     (w_isKx7 ||
                      (!w_rdMid && (w_x inside {5'd17, 5'd18, 5'd20})) ||
                      ( w_rdMid && (w_x inside {5'd11, 5'd13, 5'd14})));
    assign w_4neg  = w_isK28 ? k4Neg(w_y) : (w_useA7 ? c_A7_4B : data4Neg(w_y));
    assign w_4comp = w_isK28 || ($countones(w_4neg) != 2) ||
                     (w_y == 3'd3) || (w_y == 3'd7);
    assign w_4     = (w_rdMid && w_4comp) ? ~w_4neg : w_4neg;
    assign w_rdEnd = rdAfter4(w_rdMid, w_4);

    // Output register: capture a symbol on each accepted character, hold otherwise.
    always_ff @(posedge BitCLK_10 or posedge Reset) begin
        if (Reset) begin
            r_sym   <= 10'h000;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_valid <= bus.TxValid;
            r_err   <= bus.TxValid && w_kErr;
            if (bus.TxValid) begin
                r_sym <= toWire({w_6, w_4});
                r_rd  <= w_rdEnd;
            end
        end
    end

    assign bus.TxParallel_10 = r_sym;
    assign bus.TxValid_10    = r_valid;
    assign bus.code_error    = r_err;
    assign bus.RunDisp       = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder
//  Description : Scoreboard bench for the 8b/10b encoder. Expected symbols
//                come from the standard code tables (both RD columns listed
//                explicitly) and are compared by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encoder;
    logic BitCLK_10 = 1'b0;
    logic Reset     = 1'b1;

    encoder_if bus ();
    encoder dut (.BitCLK_10(BitCLK_10), .Reset(Reset), .bus(bus));

    always #5 BitCLK_10 = ~BitCLK_10;

    typedef struct {
        logic       valid;
        logic [9:0] sym;
        logic       err;
        logic       rd;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nErrors = 0;
    logic monOn   = 1'b0;
    logic mRd     = 1'b0;
    logic [9:0] mSym = 10'h000;
    int   runLen  = 0;
    logic lastBit = 1'b0;

    // Standard tables written in transmission order (first bit = MSB).
    logic [5:0] t6n [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] t6p [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Disparity after a sub-block of n bits held in the low bits of v.
    function automatic logic subRd(input logic rd, input logic [5:0] v, input int n);
        int ones;
        ones = $countones(v);
        if (2 * ones > n) return 1'b1;
        if (2 * ones < n) return 1'b0;
        if ((n == 6 && v == 6'b000111) || (n == 4 && v[3:0] == 4'b0011)) return 1'b1;
        if ((n == 6 && v == 6'b111000) || (n == 4 && v[3:0] == 4'b1100)) return 1'b0;
        return rd;
    endfunction

    function automatic void modelEnc(input logic k, input logic [7:0] d, input logic rdIn,
                                     output logic [9:0] sym, output logic err, output logic rdOut);
        int x, y;
        logic k28, kx7, rdMid;
        logic [5:0] s6;
        logic [3:0] s4;
        logic [9:0] tx;
        x = int'(d[4:0]);
        y = int'(d[7:5]);
        k28 = k && x == 28;
        kx7 = k && y == 7 && (x == 23 || x == 27 || x == 29 || x == 30);
        err = k && !k28 && !kx7;
        if (k28) s6 = rdIn ? 6'b110000 : 6'b001111;
        else     s6 = rdIn ? t6p[x] : t6n[x];
        rdMid = subRd(rdIn, s6, 6);
        if (k28) s4 = rdMid ? k4p[y] : k4n[y];
        else if (y == 7 && (kx7 || (!rdMid && (x == 17 || x == 18 || x == 20)) ||
                            (rdMid && (x == 11 || x == 13 || x == 14))))
            s4 = rdMid ? 4'b1000 : 4'b0111;
        else s4 = rdMid ? t4p[y] : t4n[y];
        rdOut = subRd(rdMid, {2'b00, s4}, 4);
        tx = {s6, s4};
        for (int i = 0; i < 10; i++) sym[i] = tx[9 - i];
    endfunction

    // Drive one cycle of stimulus and queue the response it must produce.
    task automatic apply(input logic v, input logic k, input logic [7:0] d);
        exp_t e;
        logic [9:0] s;
        logic er, r;
        bus.TxValid      = v;
        bus.TxDataK      = k;
        bus.TxParallel_8 = d;
        if (v) begin
            modelEnc(k, d, mRd, s, er, r);
            mSym = s;
            mRd  = r;
            e.err = er;
        end else begin
            e.err = 1'b0;
        end
        e.valid = v;
        e.sym   = mSym;
        e.rd    = mRd;
        q.push_back(e);
    endtask

    task automatic step(input logic v, input logic k, input logic [7:0] d);
        @(negedge BitCLK_10);
        apply(v, k, d);
    endtask

    task automatic expectNow(input string nm, input logic [9:0] s, input logic rd,
                             input logic err, input logic v);
        @(posedge BitCLK_10);
        #2;
        chk({nm, ".sym"},   32'(bus.TxParallel_10), 32'(s));
        chk({nm, ".rd"},    32'(bus.RunDisp),       32'(rd));
        chk({nm, ".err"},   32'(bus.code_error),    32'(err));
        chk({nm, ".valid"}, 32'(bus.TxValid_10),    32'(v));
    endtask

    task automatic chkZero(input string nm);
        chk({nm, ".sym"},   32'(bus.TxParallel_10), 32'h0);
        chk({nm, ".valid"}, 32'(bus.TxValid_10),    32'h0);
        chk({nm, ".err"},   32'(bus.code_error),    32'h0);
        chk({nm, ".rd"},    32'(bus.RunDisp),       32'h0);
    endtask

    // Reset mid-stream with a character pending on the inputs.
    task automatic midReset();
        @(negedge BitCLK_10);
        monOn = 1'b0;
        bus.TxValid      = 1'b1;
        bus.TxDataK      = 1'b1;
        bus.TxParallel_8 = 8'hBC;
        #1 Reset = 1'b1;
        #1 chkZero("midreset_async");
        @(posedge BitCLK_10);
        #1 chkZero("midreset_held");
        @(negedge BitCLK_10);
        Reset = 1'b0;
        q.delete();
        mRd = 1'b0;
        mSym = 10'h000;
        runLen = 0;
        monOn = 1'b1;
        apply(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare every output cycle against the queued expectation.
    initial begin
        exp_t e;
        int   worst;
        forever begin
            @(posedge BitCLK_10);
            #2;
            if (monOn && q.size() > 0) begin
                e = q.pop_front();
                chk("mon.valid", 32'(bus.TxValid_10), 32'(e.valid));
                chk("mon.sym",   32'(bus.TxParallel_10), 32'(e.sym));
                chk("mon.err",   32'(bus.code_error), 32'(e.err));
                chk("mon.rd",    32'(bus.RunDisp), 32'(e.rd));
                if (bus.TxValid_10 === 1'b1) begin
                    chk("mon.disparity",
                        32'($countones(bus.TxParallel_10) inside {4, 5, 6}), 32'h1);
                    worst = 0;
                    for (int i = 0; i < 10; i++) begin
                        if (runLen > 0 && bus.TxParallel_10[i] == lastBit) runLen++;
                        else runLen = 1;
                        lastBit = bus.TxParallel_10[i];
                        if (runLen > worst) worst = runLen;
                    end
                    chk("mon.runlength", 32'(worst <= 5), 32'h1);
                end
            end
        end
    end

    initial begin
        int items[$];
        int j, tmp;
        bus.TxValid = 1'b0;
        bus.TxDataK = 1'b0;
        bus.TxParallel_8 = 8'h00;

        // Power-on reset: outputs cleared before any clock edge.
        #2 chkZero("reset_async");
        @(negedge BitCLK_10);
        Reset = 1'b0;
        monOn = 1'b1;
        apply(1'b0, 1'b0, 8'h00);

        // Back-to-back comma.
        step(1'b1, 1'b1, 8'hBC); expectNow("k28.5_rdneg", 10'h17C, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hBC); expectNow("k28.5_rdpos", 10'h283, 1'b0, 1'b0, 1'b1);
        // Data bytes.
        step(1'b1, 1'b0, 8'h00); expectNow("d0.0",  10'h0B9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hB5); expectNow("d21.5", 10'h155, 1'b0, 1'b0, 1'b1);
        // Unsupported K, then an idle cycle that holds the symbol.
        step(1'b1, 1'b1, 8'h00); expectNow("badk",      10'h0B9, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'hFF); expectNow("idle_hold", 10'h0B9, 1'b0, 1'b0, 1'b0);
        // A7 substitution on both disparities.
        step(1'b1, 1'b0, 8'hF1); expectNow("d17.7_a7", 10'h3B1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hEB); expectNow("d11.7_a7", 10'h04B, 1'b0, 1'b0, 1'b1);

        // Reset while at RD+ with a character pending; restart from RD-.
        step(1'b1, 1'b1, 8'hBC);
        midReset();
        step(1'b1, 1'b1, 8'hBC); expectNow("after_reset", 10'h17C, 1'b1, 1'b0, 1'b1);

        // Full code space in random order with random idle gaps.
        for (int b = 0; b < 256; b++) items.push_back(b);
        for (int y = 0; y < 8; y++) items.push_back(256 + 28 + 32 * y);
        items.push_back(256 + 8'hF7);
        items.push_back(256 + 8'hFB);
        items.push_back(256 + 8'hFD);
        items.push_back(256 + 8'hFE);
        for (int n = 0; n < 24; n++) items.push_back(256 + int'($urandom_range(0, 255)));
        for (int i = items.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = items[i];
            items[i] = items[j];
            items[j] = tmp;
        end
        foreach (items[i]) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            step(1'b1, items[i][8], items[i][7:0]);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge BitCLK_10);
        #3;
        if (q.size() != 0) chk("drain", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/encoder.md
ENCODER -- requirements
Module: encoder

Interface
REQ-001 SHALL have port BitCLK_10  input  1  word clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port TxParallel_8  input  8  byte to encode; bits [4:0]=EDCBA (x), bits [7:5]=HGF (y).
REQ-004 SHALL have port TxDataK  input  1  1 = control character K.x.y, 0 = data character D.x.y.
REQ-005 SHALL have port TxValid  input  1  1 = TxParallel_8/TxDataK hold a character to encode this cycle.
REQ-006 SHALL have port TxParallel_10  output  10  encoded symbol, registered.
  - [5:0] = abcdei, a at bit 0.
  - [9:6] = fghj, f at bit 6.
REQ-007 SHALL have port TxValid_10  output  1  1 = TxParallel_10 holds a symbol produced from an accepted input.
REQ-008 SHALL have port code_error  output  1  1 = the accepted input was an unsupported K character.
REQ-009 SHALL have port RunDisp  output  1  current running disparity; 0 = RD-, 1 = RD+.

Function
REQ-010 SHALL encode per standard IEEE 802.3 clause 36 8b/10b tables: 5b/6b on x, 3b/4b on y.
REQ-011 SHALL select the 6b code from the RD before the character, and the 4b code from the RD after the 6b sub-block.
REQ-012 SHALL update RD per sub-block as follows:
  - more ones -> RD+.
  - more zeros -> RD-.
  - 6b 000111 or 4b 0011 (transmission order) -> RD+.
  - 6b 111000 or 4b 1100 (transmission order) -> RD-.
  - any other neutral sub-block -> RD unchanged.
REQ-013 SHALL use alternate D.x.A7 (0111/1000) instead of P7 when:
  - RD- and x in {17,18,20}, or
  - RD+ and x in {11,13,14}.
REQ-014 SHALL accept K28.0-K28.7, K23.7, K27.7, K29.7 and K30.7 as valid K characters.
REQ-015 SHALL encode K28.y with the K28 6b code (001111/110000) and the K-specific 4b codes, with no A7 substitution.
REQ-016 SHALL encode K23.7/K27.7/K29.7/K30.7 with the data 6b code plus 4b 0111/1000 chosen by RD.
REQ-017 SHALL treat any other input with TxDataK=1 as follows:
  - encode it as D.x.y of the same byte;
  - update RD from the emitted symbol;
  - assert code_error for that output cycle.
REQ-018 SHALL have a latency of exactly one BitCLK_10 cycle from a sampled TxValid=1 to the corresponding TxParallel_10/TxValid_10=1.
REQ-019 SHALL accept one character per cycle with no backpressure; back-to-back TxValid=1 produces back-to-back symbols.
REQ-020 SHALL, on a cycle with TxValid=0:
  - hold TxParallel_10 and RunDisp;
  - drive TxValid_10=0 and code_error=0 on the next edge.
REQ-021 SHALL update RunDisp on the same edge as TxParallel_10, reflecting the RD after the emitted symbol.
REQ-022 SHALL ensure every emitted symbol has disparity 0 or +/-2 and at most 5 consecutive identical bits in the stream.

Reset
REQ-023 SHALL, while Reset=1 and independent of BitCLK_10, force:
  - TxParallel_10=10'h000, TxValid_10=0, code_error=0;
  - RunDisp=0 (RD-).
REQ-024 SHALL, on Reset asserted mid-stream, discard any pending character; the first accepted character after deassertion is encoded from RD-.
REQ-025 SHALL sample inputs normally from the first rising edge after Reset deasserts.

Verification
REQ-026 SHALL cover reset: Reset=1 pulse -> all outputs 0 and RunDisp=0 asynchronously.
REQ-027 SHALL cover back-to-back comma: K28.5 (TxDataK=1, 8'hBC) twice from RD- -> 10'h17C with RunDisp=1, then 10'h283 with RunDisp=0.
REQ-028 SHALL cover a data byte: D0.0 (8'h00) from RD- -> 10'h0B9, RunDisp=0; D21.5 (8'hB5) -> 10'h155, RunDisp unchanged.
REQ-029 SHALL cover an invalid K: TxDataK=1 with 8'h00 from RD- -> 10'h0B9, code_error=1 for one cycle, RunDisp=0.
REQ-030 SHALL cover the A7 rule: D17.7 (8'hF1) at RD- and D11.7 (8'hEB) at RD+ -> 4b sub-block A7, not P7.
REQ-031 SHALL cover full-space round trip: all 256 D and 12 valid K values in random TxValid gaps -> loopback decode matches input, no disparity violation, TxValid_10 gaps mirror TxValid gaps.
